// File: rtl/switch_pkg.sv
// Shared defaults and packet-layout helpers for the N-port packet switch.
// Packet word layout, MSB first: {src[PW], dst[PW], payload[DATA_W]}.
package switch_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CNT_W      = 16;

    function automatic int pw_of(input int num_ports);
        return (num_ports < 2) ? 1 : $clog2(num_ports);
    endfunction

    function automatic int pkt_w_of(input int num_ports, input int data_w);
        return 2 * pw_of(num_ports) + data_w;
    endfunction

    function automatic int payload_lsb();
        return 0;
    endfunction

    function automatic int dst_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int src_lsb(input int num_ports, input int data_w);
        return data_w + pw_of(num_ports);
    endfunction

endpackage

// File: rtl/switch_nport_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr, wrapping
// modulo N, and returns a one-hot grant plus its index. Pointer lives in the parent.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N < 2) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    int            idx_s;
    logic [IW-1:0] idx_v_s;
    logic          hit_s;

    // First requester at or after ptr wins; later hits are masked by gnt_any.
    always_comb begin
        gnt     = {N{1'b0}};
        gnt_idx = {IW{1'b0}};
        gnt_any = 1'b0;
        idx_s   = 0;
        idx_v_s = {IW{1'b0}};
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s        = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
            idx_v_s      = IW'(idx_s);
            hit_s        = ~gnt_any & req[idx_v_s];
            gnt[idx_v_s] = gnt[idx_v_s] | hit_s;
            gnt_idx      = hit_s ? idx_v_s : gnt_idx;
            gnt_any      = gnt_any | hit_s;
        end
    end

endmodule

// File: rtl/switch_nport.sv
// N-port packet switch: per-input FIFOs, per-output register slot with
// round-robin arbitration; packets with an out-of-range dst are counted and discarded.
module switch_nport
    import switch_pkg::*;
#(
    parameter  int NUM_PORTS  = DEF_NUM_PORTS,
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int CNT_W      = DEF_CNT_W,
    localparam int PW         = pw_of(NUM_PORTS),
    localparam int PKT_W      = pkt_w_of(NUM_PORTS, DATA_W)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS-1:0]                in_valid,
    output logic [NUM_PORTS-1:0]                in_ready,
    input  logic [NUM_PORTS-1:0][PKT_W-1:0]     in_data,
    output logic [NUM_PORTS-1:0]                out_valid,
    input  logic [NUM_PORTS-1:0]                out_ready,
    output logic [NUM_PORTS-1:0][PKT_W-1:0]     out_data,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]     drop_cnt
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam int             DST_LSB  = dst_lsb(DATA_W);
    localparam logic [PW:0]    PORT_LIM = (PW+1)'(NUM_PORTS);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [NUM_PORTS-1:0]                  empty_s;
    logic [NUM_PORTS-1:0]                  wr_s;
    logic [NUM_PORTS-1:0]                  drop_s;
    logic [NUM_PORTS-1:0]                  pop_s;
    logic [NUM_PORTS-1:0]                  load_ok_s;
    logic [NUM_PORTS-1:0][PKT_W-1:0]       head_s;
    logic [NUM_PORTS-1:0][PW-1:0]          head_dst_s;
    // Both matrices are indexed [output][input].
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   req_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   gnt_s;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        logic [FIFO_DEPTH-1:0][PKT_W-1:0] mem_r;
        logic [AW-1:0]                    wr_ptr_r;
        logic [AW-1:0]                    rd_ptr_r;
        logic [AW:0]                      count_r;
        logic [CNT_W-1:0]                 drop_cnt_r;
        logic                             dst_ok_s;

        assign dst_ok_s      = ({1'b0, in_data[i][DST_LSB +: PW]} < PORT_LIM);
        assign in_ready[i]   = (count_r != FULL_CNT);
        assign wr_s[i]       = in_valid[i] & in_ready[i] & dst_ok_s;
        assign drop_s[i]     = in_valid[i] & in_ready[i] & ~dst_ok_s;
        assign empty_s[i]    = (count_r == (AW+1)'(0));
        assign head_s[i]     = mem_r[rd_ptr_r];
        assign head_dst_s[i] = head_s[i][DST_LSB +: PW];
        assign drop_cnt[i]   = drop_cnt_r;

        // Storage array: contents are only meaningful below count_r, so no reset.
        always_ff @(posedge clk) begin
            if (wr_s[i]) begin
                mem_r[wr_ptr_r] <= in_data[i];
            end
        end

        // FIFO pointers and occupancy; simultaneous write and pop leave count unchanged.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
                count_r  <= {(AW+1){1'b0}};
            end else begin
                if (wr_s[i]) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                case ({wr_s[i], pop_s[i]})
                    2'b10:   count_r <= count_r + (AW+1)'(1);
                    2'b01:   count_r <= count_r - (AW+1)'(1);
                    default: count_r <= count_r;
                endcase
            end
        end

        // Saturating count of packets discarded for an out-of-range destination.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drop_cnt_r <= {CNT_W{1'b0}};
            end else if (drop_s[i] && (drop_cnt_r != {CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
        end
    end

    // Each FIFO head requests exactly the output named by its dst field.
    always_comb begin
        req_s = {(NUM_PORTS*NUM_PORTS){1'b0}};
        pop_s = {NUM_PORTS{1'b0}};
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_s[o][i] = ~empty_s[i] & (head_dst_s[i] == PW'(o));
                pop_s[i]    = pop_s[i] | gnt_s[o][i];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [PW-1:0]        rr_r;
        logic                 valid_r;
        logic [PKT_W-1:0]     data_r;
        logic [NUM_PORTS-1:0] arb_gnt_s;
        logic [PW-1:0]        gnt_idx_s;
        logic                 gnt_any_s;

        rr_arbiter #(
            .N (NUM_PORTS)
        ) u_arb (
            .req     (req_s[o]),
            .ptr     (rr_r),
            .gnt     (arb_gnt_s),
            .gnt_idx (gnt_idx_s),
            .gnt_any (gnt_any_s)
        );

        // The slot can take a new word if empty or draining this cycle.
        assign load_ok_s[o] = ~valid_r | out_ready[o];
        assign gnt_s[o]     = load_ok_s[o] ? arb_gnt_s : {NUM_PORTS{1'b0}};
        assign out_valid[o] = valid_r;
        assign out_data[o]  = data_r;

        // Output slot and round-robin pointer; data holds while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_r    <= {PW{1'b0}};
                valid_r <= 1'b0;
                data_r  <= {PKT_W{1'b0}};
            end else if (load_ok_s[o]) begin
                valid_r <= gnt_any_s;
                if (gnt_any_s) begin
                    data_r <= head_s[gnt_idx_s];
                    rr_r   <= (gnt_idx_s == PW'(NUM_PORTS - 1)) ? {PW{1'b0}} : (gnt_idx_s + PW'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_nport.sv
// Directed self-checking bench: a 4-port switch for forwarding, arbitration,
// back-pressure, stall and reset; a 3-port, 2-bit-counter switch for drops.
module tb_switch_nport;

    logic clk = 1'b0;
    logic rst_n;

    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [3:0][11:0]  in_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [3:0][11:0]  out_data;
    logic [3:0][15:0]  drop_cnt;

    logic [2:0]        b_in_valid;
    logic [2:0]        b_in_ready;
    logic [2:0][11:0]  b_in_data;
    logic [2:0]        b_out_valid;
    logic [2:0]        b_out_ready;
    logic [2:0][11:0]  b_out_data;
    logic [2:0][1:0]   b_drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    switch_nport #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    switch_nport #(.NUM_PORTS(3), .DATA_W(8), .FIFO_DEPTH(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .drop_cnt(b_drop_cnt)
    );

    function automatic logic [11:0] pk(input logic [1:0] s, input logic [1:0] d, input logic [7:0] p);
        return {s, d, p};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b1;
        in_valid    = 4'h0;
        in_data     = 48'h0;
        out_ready   = 4'hF;
        b_in_valid  = 3'h0;
        b_in_data   = 36'h0;
        b_out_ready = 3'h7;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        #20;

        // Single packet 0 -> 2, first edge after release accepts it
        @(negedge clk);
        rst_n      = 1'b1;
        in_valid   = 4'b0001;
        in_data[0] = pk(2'd0, 2'd2, 8'h5A);
        tick();
        in_valid = 4'h0;
        check("fwd_t_idle", 64'(out_valid), 64'h0);
        tick();
        check("fwd_t1_valid", 64'(out_valid), 64'h4);
        check("fwd_t1_data", 64'(out_data[2]), 64'(pk(2'd0, 2'd2, 8'h5A)));
        tick();
        check("fwd_drained", 64'(out_valid), 64'h0);

        // All inputs to output 1: round-robin 0,1,2,3,0,... one per cycle
        for (int i = 0; i < 4; i++) in_data[i] = pk(2'(i), 2'd1, 8'h10 + 8'(i));
        in_valid = 4'hF;
        tick();
        for (int n = 0; n < 8; n++) begin
            tick();
            check("rr_valid", 64'(out_valid[1]), 64'h1);
            check("rr_order", 64'(out_data[1]), 64'(pk(2'(n % 4), 2'd1, 8'h10 + 8'(n % 4))));
        end
        in_valid = 4'h0;
        repeat (24) tick();
        check("rr_drain_valid", 64'(out_valid), 64'h0);
        check("rr_drain_ready", 64'(in_ready), 64'hF);

        // Back-pressure: 5 of 6 packets accepted while output 3 is blocked
        out_ready = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            in_valid   = 4'b0010;
            in_data[1] = pk(2'd1, 2'd3, 8'h30 + 8'(k));
            tick();
        end
        check("bp_full_ready", 64'(in_ready[1]), 64'h0);
        check("bp_out_valid", 64'(out_valid[3]), 64'h1);
        check("bp_out_head", 64'(out_data[3]), 64'(pk(2'd1, 2'd3, 8'h30)));
        in_data[1] = pk(2'd1, 2'd3, 8'h35);
        repeat (3) tick();
        check("bp_sixth_blocked", 64'(in_ready[1]), 64'h0);
        check("bp_head_hold", 64'(out_data[3]), 64'(pk(2'd1, 2'd3, 8'h30)));
        in_valid  = 4'h0;
        out_ready = 4'hF;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("bp_order", 64'({out_valid[3], out_data[3]}), 64'({1'b1, pk(2'd1, 2'd3, 8'h30 + 8'(k))}));
        end
        tick();
        check("bp_empty", 64'(out_valid[3]), 64'h0);

        // Stall: output 0 held for 10 cycles
        out_ready  = 4'b1110;
        in_valid   = 4'b0100;
        in_data[2] = pk(2'd2, 2'd0, 8'hC3);
        tick();
        in_valid = 4'h0;
        tick();
        check("stall_valid", 64'(out_valid[0]), 64'h1);
        for (int n = 0; n < 10; n++) begin
            tick();
            check("stall_hold", 64'({out_valid[0], out_data[0]}), 64'({1'b1, pk(2'd2, 2'd0, 8'hC3)}));
        end
        out_ready = 4'hF;
        tick();
        check("stall_release", 64'(out_valid[0]), 64'h0);

        // Illegal dst on the 3-port switch: counted, saturating at 3
        b_in_valid   = 3'b100;
        b_in_data[2] = pk(2'd2, 2'd3, 8'h77);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("drop_cnt", 64'(b_drop_cnt[2]), 64'((k < 3) ? k : 3));
            check("drop_ready", 64'(b_in_ready), 64'h7);
        end
        b_in_valid = 3'b000;
        tick();
        check("drop_no_fwd", 64'(b_out_valid), 64'h0);
        check("drop_others", 64'({b_drop_cnt[1], b_drop_cnt[0]}), 64'h0);
        b_in_valid   = 3'b001;
        b_in_data[0] = pk(2'd0, 2'd2, 8'hE1);
        tick();
        b_in_valid = 3'b000;
        tick();
        check("b_fwd_valid", 64'(b_out_valid), 64'h4);
        check("b_fwd_data", 64'(b_out_data[2]), 64'(pk(2'd0, 2'd2, 8'hE1)));
        check("main_no_drops", 64'(drop_cnt), 64'h0);

        // Reset mid-traffic with FIFOs partly filled
        out_ready  = 4'b0111;
        in_valid   = 4'b0011;
        in_data[0] = pk(2'd0, 2'd3, 8'hA0);
        in_data[1] = pk(2'd1, 2'd3, 8'hB0);
        repeat (3) tick();
        check("mid_busy", 64'({out_valid[3], out_data[3]}), 64'({1'b1, pk(2'd0, 2'd3, 8'hA0)}));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_ready", 64'(in_ready), 64'hF);
        check("mid_rst_data", 64'(out_data), 64'h0);
        in_valid  = 4'h0;
        out_ready = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("mid_no_stale", 64'(out_valid), 64'h0);
        end
        check("mid_drop_cnt", 64'(drop_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
